irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flip-flop synchroniser stages on each irq_in bit; legal range 2..3.
REQ-002 Port clk  input  1  SHALL be the single clock; all flops update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port irq_in  input  4  SHALL carry asynchronous interrupt source levels, bit 3 highest priority.
REQ-005 Port mask  input  4  SHALL be the per-source enable (1 = enabled), sampled synchronously.
REQ-006 Port irq_ack  input  1  SHALL be the consumer acknowledge of the presented request.
REQ-007 Port irq_req  output  1  SHALL flag a valid request on irq_id.
REQ-008 Port irq_id  output  2  SHALL give the index of the presented source.
REQ-009 Port pending  output  4  SHALL expose the raw pending register, unmasked.

Function
REQ-010 Each irq_in bit SHALL pass through SYNC_STAGES flops, then a one-flop delay for rising-edge detection.
REQ-011 A synchronised 0->1 transition SHALL set the matching pending bit on the next clock edge, for a total of SYNC_STAGES+1 clocks from the first edge that samples irq_in high; levels held high SHALL NOT re-set the bit.
REQ-012 An edge SHALL set its pending bit regardless of mask.
REQ-013 The FSM SHALL have two states, IDLE and REQ; irq_req SHALL be 1 exactly in REQ.
REQ-014 In IDLE, when (pending & mask) != 0, the FSM SHALL latch irq_id to the highest set index of (pending & mask) and move to REQ on the next edge.
REQ-015 In REQ, irq_id SHALL stay constant, even if mask or pending changes.
REQ-016 In REQ with irq_ack=1, the FSM SHALL clear pending[irq_id] and return to IDLE on that edge; irq_req SHALL be 0 for at least one cycle between consecutive requests.
REQ-017 irq_ack while in IDLE SHALL be ignored.
REQ-018 A new edge on the source being cleared in the same cycle SHALL win: the pending bit stays 1.
REQ-019 Edges on other sources during REQ SHALL set their bits and be served by priority after return to IDLE.
REQ-020 Masking the presented source while in REQ SHALL NOT withdraw irq_req; only irq_ack ends REQ.
REQ-021 Pending bits of masked sources SHALL be retained and served once unmasked.

Reset
REQ-022 While rst=1, the synchroniser flops, edge flops, pending, irq_id and FSM SHALL go to 0 / IDLE on each clock edge; irq_req=0, irq_id=2'b00, pending=4'b0000.
REQ-023 A reset asserted during REQ SHALL drop irq_req on the next edge and discard all pending events.
REQ-024 After rst falls, a level already high on irq_in SHALL register as a rising edge once synchronised.

Structure
REQ-025 Package irq_pkg SHALL hold N_SRC=4, ID_W=2 and the enumerated FSM state type {IDLE, REQ}.
REQ-026 Sub-module irq_sync SHALL implement the SYNC_STAGES synchroniser and the rising-edge pulse for one bit; irq_ctrl SHALL instantiate it N_SRC times.
REQ-027 Priority selection SHALL be combinational inside irq_ctrl, fixed with bit 3 highest.

Verification
REQ-028 With mask=4'hF and SYNC_STAGES=2, raise irq_in[1] at cycle 0 -> pending=4'b0010 at cycle 3, irq_req=1 with irq_id=1 at cycle 4.
REQ-029 Raise irq_in[0] and irq_in[2] in the same cycle -> irq_id=2 first; after ack, irq_req=0 for one cycle, then irq_id=0; after the second ack, pending=0.
REQ-030 With mask=4'b0111, raise irq_in[3] -> pending[3]=1 and irq_req stays 0; set mask=4'hF -> irq_req=1 with irq_id=3.
REQ-031 In REQ with irq_id=1, ack in the same cycle that a new irq_in[1] edge reaches the edge detector -> pending[1] stays 1 and source 1 is re-requested.
REQ-032 Assert rst for one cycle while irq_req=1 with pending=4'b1010 -> next cycle irq_req=0, irq_id=0, pending=0; no request until a new edge arrives.
REQ-033 Hold irq_in[2] high for 20 cycles with one ack -> exactly one request for source 2.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt controller.
package irq_pkg;
  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;
endpackage

// File: rtl/irq_sync.sv
// One-bit multi-flop synchroniser followed by a rising-edge pulse generator.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Synchroniser chain plus one-cycle delay of its last stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_r[SYNC_STAGES-1] & ~dly_r;
endmodule

// File: rtl/irq_ctrl.sv
// Four-source edge-triggered interrupt controller with fixed priority
// (bit 3 highest) and a request/acknowledge handshake.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending
);
  state_t           state_r, state_n;
  logic [ID_W-1:0]  id_r, id_n;
  logic [N_SRC-1:0] pending_r, pending_n;
  logic             req_r;
  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] masked_s;
  logic [N_SRC-1:0] clr_s;
  logic [ID_W-1:0]  pri_id_s;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (irq_in[g]),
      .pulse (edge_s[g])
    );
  end

  // Fixed-priority encoder over the enabled pending sources
  always_comb begin
    masked_s = pending_r & mask;
    if (masked_s[3]) begin
      pri_id_s = 2'd3;
    end else if (masked_s[2]) begin
      pri_id_s = 2'd2;
    end else if (masked_s[1]) begin
      pri_id_s = 2'd1;
    end else begin
      pri_id_s = 2'd0;
    end
  end

  // FSM next state, id latch and pending update; a fresh edge beats a same-cycle clear
  always_comb begin
    state_n = state_r;
    id_n    = id_r;
    clr_s   = {N_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (|masked_s) begin
          state_n = REQ;
          id_n    = pri_id_s;
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n = IDLE;
          clr_s   = {{(N_SRC-1){1'b0}}, 1'b1} << id_r;
        end else begin
          state_n = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    pending_n = (pending_r & ~clr_s) | edge_s;
  end

  // State, id, pending and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      id_r      <= {ID_W{1'b0}};
      pending_r <= {N_SRC{1'b0}};
      req_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      id_r      <= id_n;
      pending_r <= pending_n;
      req_r     <= (state_n == REQ);
    end
  end

  assign irq_req = req_r;
  assign irq_id  = id_r;
  assign pending = pending_r;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl with hand-written multi-cycle sequences.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_in = 4'h0;
  logic [3:0] mask = 4'hF;
  logic       irq_ack = 1'b0;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       ack;
    logic       exp_req;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[24];

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .mask    (mask),
    .irq_ack (irq_ack),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic [1:0] id, input logic [3:0] p);
    check({tag, "_req"}, {7'd0, irq_req}, {7'd0, r});
    check({tag, "_id"}, {6'd0, irq_id}, {6'd0, id});
    check({tag, "_pend"}, {4'd0, pending}, {4'd0, p});
  endtask

  initial begin
    int rises;
    logic prev;

    //         rst   in     mask   ack    req   id     pend
    vecs[0]  = '{1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[1]  = '{1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[2]  = '{1'b0, 4'h2, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[3]  = '{1'b0, 4'h2, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[4]  = '{1'b0, 4'h2, 4'hF, 1'b0, 1'b0, 2'd0, 4'h2};
    vecs[5]  = '{1'b0, 4'h2, 4'hF, 1'b0, 1'b1, 2'd1, 4'h2};
    vecs[6]  = '{1'b0, 4'h2, 4'hF, 1'b0, 1'b1, 2'd1, 4'h2};
    vecs[7]  = '{1'b0, 4'h2, 4'hF, 1'b1, 1'b0, 2'd1, 4'h0};
    vecs[8]  = '{1'b0, 4'h2, 4'hF, 1'b1, 1'b0, 2'd1, 4'h0};
    vecs[9]  = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b0, 2'd1, 4'h0};
    vecs[10] = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b0, 2'd1, 4'h0};
    vecs[11] = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b0, 2'd1, 4'h5};
    vecs[12] = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b1, 2'd2, 4'h5};
    vecs[13] = '{1'b0, 4'h7, 4'hF, 1'b1, 1'b0, 2'd2, 4'h1};
    vecs[14] = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b1, 2'd0, 4'h1};
    vecs[15] = '{1'b0, 4'h7, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0};
    vecs[16] = '{1'b0, 4'hF, 4'h7, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[17] = '{1'b0, 4'hF, 4'h7, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[18] = '{1'b0, 4'hF, 4'h7, 1'b0, 1'b0, 2'd0, 4'h8};
    vecs[19] = '{1'b0, 4'hF, 4'h7, 1'b1, 1'b0, 2'd0, 4'h8};
    vecs[20] = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 2'd3, 4'h8};
    vecs[21] = '{1'b0, 4'hF, 4'h7, 1'b0, 1'b1, 2'd3, 4'h8};
    vecs[22] = '{1'b0, 4'hF, 4'h7, 1'b1, 1'b0, 2'd3, 4'h0};
    vecs[23] = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 2'd3, 4'h0};

    for (int i = 0; i < 24; i++) begin
      rst     = vecs[i].rst;
      irq_in  = vecs[i].irq_in;
      mask    = vecs[i].mask;
      irq_ack = vecs[i].ack;
      step();
      check_all($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_id, vecs[i].exp_pend);
    end

    // Ack coinciding with a new edge on the same source: edge must win.
    irq_in  = 4'h0;
    irq_ack = 1'b0;
    mask    = 4'hF;
    for (int i = 0; i < 5; i++) step();
    irq_in = 4'h2;
    for (int i = 0; i < 4; i++) step();
    check_all("race_req", 1'b1, 2'd1, 4'h2);
    irq_in = 4'h0;
    for (int i = 0; i < 3; i++) step();
    irq_in = 4'h2;
    step();
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_all("race_ack", 1'b0, 2'd1, 4'h2);
    step();
    check_all("race_rereq", 1'b1, 2'd1, 4'h2);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    irq_in  = 4'h0;
    for (int i = 0; i < 4; i++) step();

    // Reset during REQ with two pending sources discards everything.
    irq_in = 4'hA;
    for (int i = 0; i < 3; i++) step();
    check_all("rstreq_pend", 1'b0, 2'd1, 4'hA);
    step();
    check_all("rstreq_req", 1'b1, 2'd3, 4'hA);
    rst    = 1'b1;
    irq_in = 4'h0;
    step();
    check_all("rstreq_rst", 1'b0, 2'd0, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_all("rstreq_quiet", 1'b0, 2'd0, 4'h0);

    // A level held through reset registers as an edge; a held level requests once.
    rst    = 1'b1;
    irq_in = 4'h4;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_all("held_pend", 1'b0, 2'd0, 4'h4);
    step();
    check_all("held_req", 1'b1, 2'd2, 4'h4);
    rises   = 1;
    prev    = irq_req;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (irq_req && !prev) rises++;
      prev = irq_req;
      step();
    end
    check("held_count", rises[7:0], 8'd1);
    check_all("held_end", 1'b0, 2'd2, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
